// File: rtl/mulfwd_pkg.sv
// Shared types and helpers for the Mulfwd multi-flux line buffer.
package mulfwd_pkg;

   typedef enum logic {IDLE, WORK} state_t;

   localparam int unsigned PAD_ZERO = 0;
   localparam int unsigned PAD_REPL = 1;

   // Tag width for n fluxes; a single flux still carries a 1-bit tag.
   function automatic int unsigned tag_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mulfwd_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the granted index.
module mulfwd_rr_arbiter
   import mulfwd_pkg::*;
#(
   parameter int unsigned FLUX = 2,
   localparam int unsigned TAG_WIDTH = tag_width(FLUX)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [FLUX-1:0]      req,
   output logic [TAG_WIDTH-1:0] grant,
   output logic                 valid
);

   logic [TAG_WIDTH-1:0] ptr_q, ptr_d;
   logic [TAG_WIDTH-1:0] cand [FLUX];

   always_comb begin
      for (int i = 0; i < FLUX; i++) begin
         cand[i] = TAG_WIDTH'((32'(ptr_q) + 32'(i)) % FLUX);
      end
   end

   // Scan farthest-first so the candidate nearest the pointer wins.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int i = FLUX - 1; i >= 0; i--) begin
         if (req[cand[i]]) begin
            grant = cand[i];
            valid = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (valid) begin
         ptr_d = TAG_WIDTH'((32'(grant) + 32'd1) % FLUX);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/multi_line_buffer.sv
// Multi-flux line buffer: for each input pixel emits a TAPS-tall column
// (current line plus previous lines, same column), one flux per cycle.
module multi_line_buffer
   import mulfwd_pkg::*;
#(
   parameter int unsigned FLUX       = 2,
   parameter int unsigned DATA_WIDTH = 18,
   parameter int unsigned SIZE_WIDTH = 7,
   parameter int unsigned LINE_DEPTH = 64,
   parameter int unsigned TAPS       = 3,
   parameter int unsigned PAD_MODE   = PAD_ZERO,
   localparam int unsigned TAG_WIDTH = tag_width(FLUX)
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [FLUX-1:0][TAG_WIDTH+DATA_WIDTH-1:0] read_port_in_pel_dout,
   input  logic [FLUX-1:0]                           read_port_in_pel_empty,
   output logic [FLUX-1:0]                           read_port_in_pel_read,
   input  logic [FLUX-1:0][TAG_WIDTH+SIZE_WIDTH-1:0] read_port_ext_size_dout,
   input  logic [FLUX-1:0]                           read_port_ext_size_empty,
   output logic [FLUX-1:0]                           read_port_ext_size_read,
   input  logic [FLUX-1:0][TAG_WIDTH+SIZE_WIDTH-1:0] read_port_real_size_dout,
   input  logic [FLUX-1:0]                           read_port_real_size_empty,
   output logic [FLUX-1:0]                           read_port_real_size_read,
   output logic [TAG_WIDTH+TAPS*DATA_WIDTH-1:0]      write_port_out_pel_din,
   input  logic [FLUX-1:0]                           write_port_out_pel_full,
   output logic [FLUX-1:0]                           write_port_out_pel_write,
   output logic [FLUX-1:0]                           err_size
);

   localparam int unsigned WORD_WIDTH = (TAPS - 1) * DATA_WIDTH;
   localparam int unsigned ADDR_WIDTH = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
   localparam int unsigned TIDX_WIDTH = $clog2(TAPS);

   state_t                state_q [FLUX];
   state_t                state_d [FLUX];
   logic [SIZE_WIDTH-1:0] cnt_h_q [FLUX];
   logic [SIZE_WIDTH-1:0] cnt_h_d [FLUX];
   logic [SIZE_WIDTH-1:0] cnt_v_q [FLUX];
   logic [SIZE_WIDTH-1:0] cnt_v_d [FLUX];
   logic [SIZE_WIDTH-1:0] max_h_q [FLUX];
   logic [SIZE_WIDTH-1:0] max_h_d [FLUX];
   logic [SIZE_WIDTH-1:0] max_v_q [FLUX];
   logic [SIZE_WIDTH-1:0] max_v_d [FLUX];
   logic [FLUX-1:0]       err_q, err_d;

   logic [WORD_WIDTH-1:0] ram [FLUX][LINE_DEPTH];

   logic [FLUX-1:0]          elig;
   logic [TAG_WIDTH-1:0]     tag;
   logic                     arb_valid, fire, pel_fire;
   logic [SIZE_WIDTH-1:0]    cur_h, cur_v, hdr_real, hdr_ext;
   logic [ADDR_WIDTH-1:0]    addr;
   logic [WORD_WIDTH-1:0]    rd_word, wr_word;
   logic [DATA_WIDTH-1:0]    raw [TAPS];
   logic [DATA_WIDTH-1:0]    tap [TAPS];
   logic [TAPS*DATA_WIDTH-1:0] taps_flat;
   logic                     unused_tag_bits;

   always_comb begin
      for (int f = 0; f < FLUX; f++) begin
         if (state_q[f] == IDLE) begin
            elig[f] = !read_port_ext_size_empty[f] && !read_port_real_size_empty[f];
         end else begin
            elig[f] = !read_port_in_pel_empty[f] && !write_port_out_pel_full[f];
         end
      end
   end

   mulfwd_rr_arbiter #(
      .FLUX (FLUX)
   ) u_arbiter (
      .clk   (clk),
      .rst   (rst),
      .req   (elig),
      .grant (tag),
      .valid (arb_valid)
   );

   // Gating with rst keeps every strobe low the moment reset asserts.
   assign fire     = arb_valid & rst;
   assign pel_fire = fire && (state_q[tag] == WORK);

   always_comb begin
      cur_h   = cnt_h_q[tag];
      cur_v   = cnt_v_q[tag];
      addr    = ADDR_WIDTH'(cur_h);
      rd_word = ram[tag][addr];
      raw[0]  = read_port_in_pel_dout[tag][DATA_WIDTH-1:0];
      for (int k = 1; k < TAPS; k++) begin
         raw[k] = rd_word[(k-1)*DATA_WIDTH +: DATA_WIDTH];
      end
      wr_word = '0;
      for (int k = 1; k < TAPS; k++) begin
         wr_word[(k-1)*DATA_WIDTH +: DATA_WIDTH] = raw[k-1];
      end
      // Rows above the frame top are padded on the output only.
      tap[0] = raw[0];
      for (int k = 1; k < TAPS; k++) begin
         if (int'(cur_v) >= k) begin
            tap[k] = raw[k];
         end else if (PAD_MODE == PAD_REPL) begin
            tap[k] = raw[TIDX_WIDTH'(cur_v)];
         end else begin
            tap[k] = '0;
         end
      end
      taps_flat = '0;
      for (int k = 0; k < TAPS; k++) begin
         taps_flat[k*DATA_WIDTH +: DATA_WIDTH] = tap[k];
      end
   end

   assign write_port_out_pel_din = {tag, taps_flat};

   always_comb begin
      state_d = state_q;
      cnt_h_d = cnt_h_q;
      cnt_v_d = cnt_v_q;
      max_h_d = max_h_q;
      max_v_d = max_v_q;
      err_d   = err_q;
      read_port_in_pel_read    = '0;
      read_port_ext_size_read  = '0;
      read_port_real_size_read = '0;
      write_port_out_pel_write = '0;
      hdr_real = read_port_real_size_dout[tag][SIZE_WIDTH-1:0];
      hdr_ext  = read_port_ext_size_dout[tag][SIZE_WIDTH-1:0];
      if (fire) begin
         if (state_q[tag] == IDLE) begin
            read_port_ext_size_read[tag]  = 1'b1;
            read_port_real_size_read[tag] = 1'b1;
            if (hdr_real == '0 || hdr_ext == '0) begin
               err_d[tag] = 1'b1;
            end else begin
               state_d[tag] = WORK;
               cnt_h_d[tag] = '0;
               cnt_v_d[tag] = '0;
               max_v_d[tag] = hdr_ext;
               if (32'(hdr_real) > LINE_DEPTH) begin
                  max_h_d[tag] = SIZE_WIDTH'(LINE_DEPTH);
                  err_d[tag]   = 1'b1;
               end else begin
                  max_h_d[tag] = hdr_real;
               end
            end
         end else begin
            read_port_in_pel_read[tag]    = 1'b1;
            write_port_out_pel_write[tag] = 1'b1;
            if (cur_h < max_h_q[tag] - SIZE_WIDTH'(1)) begin
               cnt_h_d[tag] = cur_h + SIZE_WIDTH'(1);
            end else if (cur_v < max_v_q[tag] - SIZE_WIDTH'(1)) begin
               cnt_h_d[tag] = '0;
               cnt_v_d[tag] = cur_v + SIZE_WIDTH'(1);
            end else begin
               cnt_h_d[tag] = '0;
               cnt_v_d[tag] = '0;
               state_d[tag] = IDLE;
            end
         end
      end
   end

   always_comb begin
      unused_tag_bits = 1'b0;
      for (int f = 0; f < FLUX; f++) begin
         unused_tag_bits = unused_tag_bits ^
            (^{read_port_in_pel_dout[f][TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH],
               read_port_ext_size_dout[f][TAG_WIDTH+SIZE_WIDTH-1:SIZE_WIDTH],
               read_port_real_size_dout[f][TAG_WIDTH+SIZE_WIDTH-1:SIZE_WIDTH]});
      end
   end

   // Line RAM is never reset; rows not yet written are always padded.
   always_ff @(posedge clk) begin
      if (pel_fire) begin
         ram[tag][addr] <= wr_word;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int f = 0; f < FLUX; f++) begin
            state_q[f] <= IDLE;
            cnt_h_q[f] <= '0;
            cnt_v_q[f] <= '0;
            max_h_q[f] <= '0;
            max_v_q[f] <= '0;
         end
         err_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_h_q <= cnt_h_d;
         cnt_v_q <= cnt_v_d;
         max_h_q <= max_h_d;
         max_v_q <= max_v_d;
         err_q   <= err_d;
      end
   end

   assign err_size = err_q;

endmodule

// File: tb/tb_multi_line_buffer.sv
// Scoreboard bench for multi_line_buffer: queue-modelled FIFOs feed two
// instances (zero and replicate padding); a monitor checks every write.
module tb_multi_line_buffer;
   import mulfwd_pkg::*;

   localparam int unsigned FLUX = 2;
   localparam int unsigned DW   = 18;
   localparam int unsigned SW   = 7;
   localparam int unsigned LD   = 64;
   localparam int unsigned TAPS = 3;
   localparam int unsigned TW   = 1;
   localparam int unsigned OW   = TW + TAPS * DW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [FLUX-1:0][TW+DW-1:0] a_pel_dout, b_pel_dout;
   logic [FLUX-1:0][TW+SW-1:0] a_ext_dout, b_ext_dout, a_real_dout, b_real_dout;
   logic [FLUX-1:0] a_pel_empty, a_pel_read, a_ext_empty, a_ext_read;
   logic [FLUX-1:0] a_real_empty, a_real_read, a_full, a_write, a_err;
   logic [FLUX-1:0] b_pel_empty, b_pel_read, b_ext_empty, b_ext_read;
   logic [FLUX-1:0] b_real_empty, b_real_read, b_full, b_write, b_err;
   logic [OW-1:0]   a_din, b_din;

   multi_line_buffer #(
      .FLUX(FLUX), .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .LINE_DEPTH(LD), .TAPS(TAPS),
      .PAD_MODE(PAD_ZERO)
   ) u_dut_a (
      .clk(clk), .rst(rst),
      .read_port_in_pel_dout(a_pel_dout), .read_port_in_pel_empty(a_pel_empty),
      .read_port_in_pel_read(a_pel_read),
      .read_port_ext_size_dout(a_ext_dout), .read_port_ext_size_empty(a_ext_empty),
      .read_port_ext_size_read(a_ext_read),
      .read_port_real_size_dout(a_real_dout), .read_port_real_size_empty(a_real_empty),
      .read_port_real_size_read(a_real_read),
      .write_port_out_pel_din(a_din), .write_port_out_pel_full(a_full),
      .write_port_out_pel_write(a_write), .err_size(a_err)
   );

   multi_line_buffer #(
      .FLUX(FLUX), .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .LINE_DEPTH(LD), .TAPS(TAPS),
      .PAD_MODE(PAD_REPL)
   ) u_dut_b (
      .clk(clk), .rst(rst),
      .read_port_in_pel_dout(b_pel_dout), .read_port_in_pel_empty(b_pel_empty),
      .read_port_in_pel_read(b_pel_read),
      .read_port_ext_size_dout(b_ext_dout), .read_port_ext_size_empty(b_ext_empty),
      .read_port_ext_size_read(b_ext_read),
      .read_port_real_size_dout(b_real_dout), .read_port_real_size_empty(b_real_empty),
      .read_port_real_size_read(b_real_read),
      .write_port_out_pel_din(b_din), .write_port_out_pel_full(b_full),
      .write_port_out_pel_write(b_write), .err_size(b_err)
   );

   logic [SW-1:0] a_hr0[$], a_hr1[$], a_he0[$], a_he1[$], b_hr[$], b_he[$];
   logic [DW-1:0] a_p0[$], a_p1[$], b_p[$];
   logic [OW-1:0] a_sb0[$], a_sb1[$], b_sb[$];
   int            glog[$];

   int n_chk = 0;
   int n_err = 0;
   int wr_cnt [FLUX] = '{0, 0};
   logic win = 1'b0;
   int win_wr0 = 0, win_wr1 = 0, win_rd0 = 0;

   // Hand-computed columns {tap2, tap1, tap0} for a 4x3 frame of pels 1..12.
   int tbl_zero [12][3] = '{'{0,0,1}, '{0,0,2}, '{0,0,3}, '{0,0,4},
                            '{0,1,5}, '{0,2,6}, '{0,3,7}, '{0,4,8},
                            '{1,5,9}, '{2,6,10}, '{3,7,11}, '{4,8,12}};
   int tbl_repl [12][3] = '{'{1,1,1}, '{2,2,2}, '{3,3,3}, '{4,4,4},
                            '{1,1,5}, '{2,2,6}, '{3,3,7}, '{4,4,8},
                            '{1,5,9}, '{2,6,10}, '{3,7,11}, '{4,8,12}};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [OW-1:0] col(input int tag, input int t2, input int t1, input int t0);
      return {TW'(tag), DW'(t2), DW'(t1), DW'(t0)};
   endfunction

   // Zero-padded column for the idx-th pel (value p) of a frame w columns wide.
   function automatic logic [OW-1:0] mdl(input int tag, input int p, input int idx, input int w);
      int v;
      v = idx / w;
      return col(tag, (v >= 2) ? p - 2 * w : 0, (v >= 1) ? p - w : 0, p);
   endfunction

   task automatic refresh();
      a_real_empty = {a_hr1.size() == 0, a_hr0.size() == 0};
      a_ext_empty  = {a_he1.size() == 0, a_he0.size() == 0};
      a_pel_empty  = {a_p1.size() == 0, a_p0.size() == 0};
      a_real_dout[0] = {1'b0, (a_hr0.size() != 0) ? a_hr0[0] : SW'(0)};
      a_real_dout[1] = {1'b1, (a_hr1.size() != 0) ? a_hr1[0] : SW'(0)};
      a_ext_dout[0]  = {1'b0, (a_he0.size() != 0) ? a_he0[0] : SW'(0)};
      a_ext_dout[1]  = {1'b1, (a_he1.size() != 0) ? a_he1[0] : SW'(0)};
      a_pel_dout[0]  = {1'b0, (a_p0.size() != 0) ? a_p0[0] : DW'(0)};
      a_pel_dout[1]  = {1'b1, (a_p1.size() != 0) ? a_p1[0] : DW'(0)};
      b_real_empty = {1'b1, b_hr.size() == 0};
      b_ext_empty  = {1'b1, b_he.size() == 0};
      b_pel_empty  = {1'b1, b_p.size() == 0};
      b_real_dout[0] = {1'b0, (b_hr.size() != 0) ? b_hr[0] : SW'(0)};
      b_ext_dout[0]  = {1'b0, (b_he.size() != 0) ? b_he[0] : SW'(0)};
      b_pel_dout[0]  = {1'b0, (b_p.size() != 0) ? b_p[0] : DW'(0)};
      b_real_dout[1] = '0;
      b_ext_dout[1]  = '0;
      b_pel_dout[1]  = '0;
   endtask

   task automatic push_hdr(input int f, input int real_sz, input int ext_sz);
      if (f == 0) begin
         a_hr0.push_back(SW'(real_sz));
         a_he0.push_back(SW'(ext_sz));
      end else begin
         a_hr1.push_back(SW'(real_sz));
         a_he1.push_back(SW'(ext_sz));
      end
   endtask

   task automatic push_frame(input int f, input int first, input int n, input int w);
      for (int i = 0; i < n; i++) begin
         if (f == 0) begin
            a_p0.push_back(DW'(first + i));
            a_sb0.push_back(mdl(0, first + i, i, w));
         end else begin
            a_p1.push_back(DW'(first + i));
            a_sb1.push_back(mdl(1, first + i, i, w));
         end
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while ((a_sb0.size() + a_sb1.size() + b_sb.size()) != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check({name, "_drain_outstanding"}, 64'(a_sb0.size() + a_sb1.size() + b_sb.size()), 0);
      @(posedge clk);
      #2;
   endtask

   task automatic wait_wr0(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (wr_cnt[0] < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      check({name, "_wr0_reached"}, 64'(wr_cnt[0] >= target), 1);
   endtask

   // FIFO model: strobes sampled at the falling edge are applied after the rising edge.
   initial begin : fifo_pop
      logic [FLUX-1:0] ar, ae, ap;
      logic br, be, bp;
      forever begin
         @(negedge clk);
         ar = a_real_read; ae = a_ext_read; ap = a_pel_read;
         br = b_real_read[0]; be = b_ext_read[0]; bp = b_pel_read[0];
         @(posedge clk);
         #1;
         if (ar[0] && a_hr0.size() != 0) void'(a_hr0.pop_front());
         if (ar[1] && a_hr1.size() != 0) void'(a_hr1.pop_front());
         if (ae[0] && a_he0.size() != 0) void'(a_he0.pop_front());
         if (ae[1] && a_he1.size() != 0) void'(a_he1.pop_front());
         if (ap[0] && a_p0.size() != 0) void'(a_p0.pop_front());
         if (ap[1] && a_p1.size() != 0) void'(a_p1.pop_front());
         if (br && b_hr.size() != 0) void'(b_hr.pop_front());
         if (be && b_he.size() != 0) void'(b_he.pop_front());
         if (bp && b_p.size() != 0) void'(b_p.pop_front());
         refresh();
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (win && a_pel_read[0]) win_rd0++;
         if (a_write[0]) begin
            wr_cnt[0]++;
            glog.push_back(0);
            if (win) win_wr0++;
            if (a_sb0.size() == 0) check("a_out0_unexpected", 64'(a_din), 0);
            else check("a_out0", 64'(a_din), 64'(a_sb0.pop_front()));
         end
         if (a_write[1]) begin
            wr_cnt[1]++;
            glog.push_back(1);
            if (win) win_wr1++;
            if (a_sb1.size() == 0) check("a_out1_unexpected", 64'(a_din), 0);
            else check("a_out1", 64'(a_din), 64'(a_sb1.pop_front()));
         end
         if (b_write[0]) begin
            if (b_sb.size() == 0) check("b_out0_unexpected", 64'(b_din), 0);
            else check("b_out0", 64'(b_din), 64'(b_sb.pop_front()));
         end
         if (b_write[1]) check("b_write1", 64'(b_write[1]), 0);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1);
   end

   initial begin : stimulus
      int base0, base1, viol;
      a_full = '0;
      b_full = '0;
      refresh();
      repeat (3) @(posedge clk);
      #1;
      check("reset_err_a", 64'(a_err), 0);
      check("reset_err_b", 64'(b_err), 0);
      check("reset_strobes_a", 64'({a_pel_read, a_ext_read, a_real_read, a_write}), 0);
      @(negedge clk);
      rst = 1'b1;

      // Single frame 4x3, both padding modes.
      @(posedge clk);
      #2;
      push_hdr(0, 4, 3);
      b_hr.push_back(SW'(4));
      b_he.push_back(SW'(3));
      for (int i = 0; i < 12; i++) begin
         a_p0.push_back(DW'(i + 1));
         b_p.push_back(DW'(i + 1));
         a_sb0.push_back(col(0, tbl_zero[i][0], tbl_zero[i][1], tbl_zero[i][2]));
         b_sb.push_back(col(0, tbl_repl[i][0], tbl_repl[i][1], tbl_repl[i][2]));
      end
      refresh();
      wait_drain("frame4x3", 100);
      check("frame4x3_writes_f0", 64'(wr_cnt[0]), 12);
      check("frame4x3_writes_f1", 64'(wr_cnt[1]), 0);
      a_p0.push_back(DW'(999));
      refresh();
      repeat (4) @(posedge clk);
      #2;
      check("frame4x3_idle_after", 64'(a_p0.size()), 1);
      a_p0.delete();
      refresh();

      // Both fluxes ready every cycle: write grants must alternate.
      glog.delete();
      push_hdr(0, 2, 2);
      push_hdr(1, 2, 2);
      push_frame(0, 101, 4, 2);
      push_frame(1, 201, 4, 2);
      refresh();
      wait_drain("interleave", 100);
      check("interleave_writes", 64'(glog.size()), 8);
      viol = 0;
      for (int i = 1; i < glog.size(); i++) begin
         if (glog[i] == glog[i-1]) viol++;
      end
      check("interleave_alternation_violations", 64'(viol), 0);

      // Back-pressure on flux0 for five cycles mid-frame.
      base0 = wr_cnt[0];
      push_hdr(0, 3, 2);
      push_hdr(1, 4, 3);
      push_frame(0, 301, 6, 3);
      push_frame(1, 401, 12, 4);
      refresh();
      wait_wr0("backpressure", base0 + 2, 50);
      #2;
      a_full[0] = 1'b1;
      win_wr0 = 0;
      win_wr1 = 0;
      win_rd0 = 0;
      win = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      win = 1'b0;
      @(posedge clk);
      #2;
      a_full[0] = 1'b0;
      check("backpressure_f1_grants", 64'(win_wr1), 5);
      check("backpressure_f0_writes", 64'(win_wr0), 0);
      check("backpressure_f0_reads", 64'(win_rd0), 0);
      wait_drain("backpressure", 100);

      // Oversized line is clamped; zero-row header is rejected.
      base1 = wr_cnt[1];
      push_hdr(0, 100, 2);
      push_hdr(1, 5, 0);
      push_frame(0, 1001, 128, 64);
      refresh();
      wait_drain("clamp", 300);
      check("size_err_flags", 64'(a_err), 2'b11);
      check("zero_hdr_popped", 64'(a_hr1.size() + a_he1.size()), 0);
      check("zero_hdr_no_output", 64'(wr_cnt[1] - base1), 0);
      a_p0.push_back(DW'(7));
      a_p1.push_back(DW'(8));
      refresh();
      repeat (4) @(posedge clk);
      #2;
      check("clamp_zero_idle_after", 64'(a_p0.size() + a_p1.size()), 2);
      a_p0.delete();
      a_p1.delete();
      refresh();

      // Reset in the middle of row 2, then a fresh frame.
      base0 = wr_cnt[0];
      push_hdr(0, 4, 4);
      push_frame(0, 501, 16, 4);
      refresh();
      wait_wr0("reset_mid", base0 + 9, 50);
      #3;
      rst = 1'b0;
      #1;
      check("reset_async_strobes", 64'({a_pel_read, a_ext_read, a_real_read, a_write}), 0);
      check("reset_err_cleared", 64'(a_err), 0);
      a_p0.delete();
      a_sb0.delete();
      refresh();
      @(negedge clk);
      rst = 1'b1;
      base0 = wr_cnt[0];
      @(posedge clk);
      #2;
      push_hdr(0, 4, 3);
      push_frame(0, 601, 12, 4);
      refresh();
      wait_drain("post_reset", 100);
      check("post_reset_writes", 64'(wr_cnt[0] - base0), 12);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
